// File: rtl/uart_cmd_bridge_if.sv
// Byte-FIFO and register-bus bundle for uart_cmd_bridge.
// master: the bridge side; slave: FIFOs plus register file side.
interface uart_cmd_bridge_if #(
  parameter int ADDR_W = 8
);
  logic              rx_empty;
  logic              rx_rd_en;
  logic [7:0]        rx_rd_data;
  logic              tx_full;
  logic              tx_wr_en;
  logic [7:0]        tx_wr_data;
  logic [ADDR_W-1:0] reg_addr;
  logic              reg_wr_en;
  logic [7:0]        reg_wr_data;
  logic              reg_rd_en;
  logic [7:0]        reg_rd_data;
  logic              busy;
  logic              err;

  modport master (
    input  rx_empty, rx_rd_data, tx_full, reg_rd_data,
    output rx_rd_en, tx_wr_en, tx_wr_data, reg_addr, reg_wr_en,
           reg_wr_data, reg_rd_en, busy, err
  );

  modport slave (
    output rx_empty, rx_rd_data, tx_full, reg_rd_data,
    input  rx_rd_en, tx_wr_en, tx_wr_data, reg_addr, reg_wr_en,
           reg_wr_data, reg_rd_en, busy, err
  );
endinterface

// File: rtl/uart_cmd_bridge.sv
// UART command bridge: pops 'W'/'R' frames from the RX FIFO, drives
// register read/write strobes and pushes one reply byte per frame.
// Optional trailing XOR checksum byte: define UART_BRIDGE_CSUM_EN.
module uart_cmd_bridge #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst,
  uart_cmd_bridge_if.master bus
);
  localparam int               CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       CMD_W    = 8'h57;
  localparam logic [7:0]       CMD_R    = 8'h52;
  localparam logic [7:0]       RSP_OK   = 8'h4B;
  localparam logic [7:0]       RSP_BAD  = 8'h3F;
`ifdef UART_BRIDGE_CSUM_EN
  localparam logic [7:0]       RSP_CSUM = 8'h45;
`endif

  typedef enum logic [3:0] {
    IDLE, WAIT_CMD, DECODE, GET_ADDR, WAIT_ADDR, GET_DATA, WAIT_DATA,
`ifdef UART_BRIDGE_CSUM_EN
    GET_CSUM, WAIT_CSUM,
`endif
    REG_WR, REG_RD, RD_WAIT, SEND
  } state_t;

  state_t            r_state;
  state_t            w_wait_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [7:0]        r_cmd;
`ifdef UART_BRIDGE_CSUM_EN
  logic [7:0]        r_csum;
`endif
  logic              r_rx_rd_en;
  logic              r_tx_wr_en;
  logic [7:0]        r_tx_wr_data;
  logic [ADDR_W-1:0] r_addr;
  logic              r_reg_wr_en;
  logic [7:0]        r_reg_wr_data;
  logic              r_reg_rd_en;
  logic              r_err;

  assign bus.rx_rd_en    = r_rx_rd_en;
  assign bus.tx_wr_en    = r_tx_wr_en;
  assign bus.tx_wr_data  = r_tx_wr_data;
  assign bus.reg_addr    = r_addr;
  assign bus.reg_wr_en   = r_reg_wr_en;
  assign bus.reg_wr_data = r_reg_wr_data;
  assign bus.reg_rd_en   = r_reg_rd_en;
  assign bus.err         = r_err;
  assign bus.busy        = (r_state != IDLE);

  // Wait state that follows each byte-fetch state.
  always_comb begin
    w_wait_state = WAIT_CMD;
    case (r_state)
      GET_ADDR: w_wait_state = WAIT_ADDR;
      GET_DATA: w_wait_state = WAIT_DATA;
`ifdef UART_BRIDGE_CSUM_EN
      GET_CSUM: w_wait_state = WAIT_CSUM;
`endif
      default:  w_wait_state = WAIT_CMD;
    endcase
  end

  // Frame FSM with registered strobes. WAIT_* spans two cycles: the pop
  // cycle (r_rx_rd_en high) and the cycle in which FIFO data is valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_cmd         <= '0;
`ifdef UART_BRIDGE_CSUM_EN
      r_csum        <= '0;
`endif
      r_rx_rd_en    <= 1'b0;
      r_tx_wr_en    <= 1'b0;
      r_tx_wr_data  <= '0;
      r_addr        <= '0;
      r_reg_wr_en   <= 1'b0;
      r_reg_wr_data <= '0;
      r_reg_rd_en   <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_rx_rd_en  <= 1'b0;
      r_tx_wr_en  <= 1'b0;
      r_reg_wr_en <= 1'b0;
      r_reg_rd_en <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!bus.rx_empty) begin
            r_rx_rd_en <= 1'b1;
            r_state    <= WAIT_CMD;
          end
        end
        WAIT_CMD: begin
          if (!r_rx_rd_en) begin
            r_cmd   <= bus.rx_rd_data;
            r_state <= DECODE;
          end
        end
        DECODE: begin
          if (r_cmd == CMD_W || r_cmd == CMD_R) begin
            r_cnt   <= '0;
`ifdef UART_BRIDGE_CSUM_EN
            r_csum  <= r_cmd;
`endif
            r_state <= GET_ADDR;
          end else begin
            r_err        <= 1'b1;
            r_tx_wr_data <= RSP_BAD;
            r_tx_wr_en   <= !bus.tx_full;
            r_state      <= SEND;
          end
        end
`ifdef UART_BRIDGE_CSUM_EN
        GET_ADDR, GET_DATA, GET_CSUM: begin
`else
        GET_ADDR, GET_DATA: begin
`endif
          if (!bus.rx_empty) begin
            r_rx_rd_en <= 1'b1;
            r_state    <= w_wait_state;
          end else if (r_cnt == CNT_MAX) begin
            r_err   <= 1'b1;
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT_ADDR: begin
          if (!r_rx_rd_en) begin
            r_addr <= bus.rx_rd_data[ADDR_W-1:0];
            r_cnt  <= '0;
`ifdef UART_BRIDGE_CSUM_EN
            r_csum <= r_csum ^ bus.rx_rd_data;
            r_state <= (r_cmd == CMD_W) ? GET_DATA : GET_CSUM;
`else
            if (r_cmd == CMD_W) begin
              r_state <= GET_DATA;
            end else begin
              r_reg_rd_en <= 1'b1;
              r_state     <= REG_RD;
            end
`endif
          end
        end
        WAIT_DATA: begin
          if (!r_rx_rd_en) begin
            r_reg_wr_data <= bus.rx_rd_data;
            r_cnt         <= '0;
`ifdef UART_BRIDGE_CSUM_EN
            r_csum        <= r_csum ^ bus.rx_rd_data;
            r_state       <= GET_CSUM;
`else
            r_reg_wr_en   <= 1'b1;
            r_state       <= REG_WR;
`endif
          end
        end
`ifdef UART_BRIDGE_CSUM_EN
        WAIT_CSUM: begin
          if (!r_rx_rd_en) begin
            r_cnt <= '0;
            if (bus.rx_rd_data != r_csum) begin
              r_err        <= 1'b1;
              r_tx_wr_data <= RSP_CSUM;
              r_tx_wr_en   <= !bus.tx_full;
              r_state      <= SEND;
            end else if (r_cmd == CMD_W) begin
              r_reg_wr_en <= 1'b1;
              r_state     <= REG_WR;
            end else begin
              r_reg_rd_en <= 1'b1;
              r_state     <= REG_RD;
            end
          end
        end
`endif
        REG_WR: begin
          r_tx_wr_data <= RSP_OK;
          r_tx_wr_en   <= !bus.tx_full;
          r_state      <= SEND;
        end
        REG_RD: begin
          r_state <= RD_WAIT;
        end
        RD_WAIT: begin
          r_tx_wr_data <= bus.reg_rd_data;
          r_tx_wr_en   <= !bus.tx_full;
          r_state      <= SEND;
        end
        SEND: begin
          // Push is granted on entry when the FIFO has room; otherwise wait.
          if (r_tx_wr_en) begin
            r_state <= IDLE;
          end else if (!bus.tx_full) begin
            r_tx_wr_en <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Directed bench for uart_cmd_bridge; RX FIFO and register file are
// modelled in the single stimulus thread. Honours UART_BRIDGE_CSUM_EN.
module tb_uart_cmd_bridge;
  localparam int ADDR_W = 8;
  localparam int TMO    = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_cmd_bridge_if #(.ADDR_W(ADDR_W)) bus ();

  uart_cmd_bridge #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] rxq[$];
  logic [7:0] rd_value;
  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int n_wr, n_rd, n_tx, n_err, n_both, n_consec, n_full_push, n_underflow;
  int wr_cyc, tx_cyc;
  logic [7:0] wr_addr, wr_data, rd_addr, tx_byte;
  logic prev_rd = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    n_wr = 0; n_rd = 0; n_tx = 0; n_err = 0;
    wr_cyc = -100; tx_cyc = 0;
    wr_addr = '0; wr_data = '0; rd_addr = '0; tx_byte = '0;
  endtask

  // Observe the current cycle, then advance one edge and update the models.
  task automatic tick();
    logic rd_now, rrd_now;
    if (bus.rx_rd_en && prev_rd) n_consec++;
    prev_rd = bus.rx_rd_en;
    if (bus.reg_wr_en) begin n_wr++; wr_addr = bus.reg_addr; wr_data = bus.reg_wr_data; wr_cyc = cyc; end
    if (bus.reg_rd_en) begin n_rd++; rd_addr = bus.reg_addr; end
    if (bus.reg_wr_en && bus.reg_rd_en) n_both++;
    if (bus.tx_wr_en) begin
      n_tx++; tx_byte = bus.tx_wr_data; tx_cyc = cyc;
      if (bus.tx_full) n_full_push++;
    end
    if (bus.err) n_err++;
    rd_now  = bus.rx_rd_en;
    rrd_now = bus.reg_rd_en;
    @(posedge clk);
    #1;
    cyc++;
    if (rd_now) begin
      if (rxq.size() > 0) bus.rx_rd_data = rxq.pop_front();
      else n_underflow++;
    end
    bus.reg_rd_data = rrd_now ? rd_value : 8'h00;
    bus.rx_empty    = (rxq.size() == 0);
  endtask

  task automatic tick_n(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [7:0] b);
    rxq.push_back(b);
    bus.rx_empty = 1'b0;
  endtask

  task automatic send_w(input logic [7:0] a, input logic [7:0] d);
    push(8'h57); push(a); push(d);
`ifdef UART_BRIDGE_CSUM_EN
    push(8'h57 ^ a ^ d);
`endif
  endtask

  task automatic send_r(input logic [7:0] a);
    push(8'h52); push(a);
`ifdef UART_BRIDGE_CSUM_EN
    push(8'h52 ^ a);
`endif
  endtask

  initial begin
    rst = 1'b0;
    bus.rx_empty = 1'b1; bus.rx_rd_data = '0; bus.tx_full = 1'b0; bus.reg_rd_data = '0;
    rd_value = '0;
    n_both = 0; n_consec = 0; n_full_push = 0; n_underflow = 0;
    clr();
    @(posedge clk); #1;
    tick_n(3);
    check("rst_strobes", {bus.busy, bus.rx_rd_en, bus.tx_wr_en, bus.reg_wr_en, bus.reg_rd_en, bus.err}, 0);
    check("rst_data", {bus.reg_addr, bus.reg_wr_data, bus.tx_wr_data}, 0);
    rst = 1'b1;
    tick_n(2);

    // Write frame
    clr(); send_w(8'h05, 8'hA5); tick_n(40);
    check("wr_count", n_wr, 1);
    check("wr_addr", wr_addr, 8'h05);
    check("wr_data", wr_data, 8'hA5);
    check("wr_no_rd", n_rd, 0);
    check("wr_tx_count", n_tx, 1);
    check("wr_tx_byte", tx_byte, 8'h4B);
    check("wr_tx_latency", tx_cyc - wr_cyc, 1);
    check("wr_no_err", n_err, 0);
    check("wr_idle", bus.busy, 0);

    // Read frame
    rd_value = 8'h3C;
    clr(); send_r(8'h03); tick_n(40);
    check("rd_count", n_rd, 1);
    check("rd_addr", rd_addr, 8'h03);
    check("rd_no_wr", n_wr, 0);
    check("rd_tx_count", n_tx, 1);
    check("rd_tx_byte", tx_byte, 8'h3C);

    // Bad command, then a normal write
    clr(); push(8'h00); tick_n(30);
    check("bad_err", n_err, 1);
    check("bad_tx_count", n_tx, 1);
    check("bad_tx_byte", tx_byte, 8'h3F);
    check("bad_no_reg", n_wr + n_rd, 0);
    clr(); send_w(8'h01, 8'h11); tick_n(40);
    check("after_bad_wr", {wr_addr, wr_data}, 16'h0111);
    check("after_bad_tx", {n_tx[7:0], tx_byte}, 16'h014B);
    check("after_bad_no_err", n_err, 0);

    // Timeout waiting for the data byte
    clr(); push(8'h57); push(8'h05); tick_n(15);
    check("tmo_not_early", n_err, 0);
    check("tmo_busy_wait", bus.busy, 1);
    tick_n(25);
    check("tmo_err", n_err, 1);
    check("tmo_idle", bus.busy, 0);
    check("tmo_no_wr", n_wr, 0);
    check("tmo_no_tx", n_tx, 0);

    // Back-pressure on the reply
    bus.tx_full = 1'b1;
    clr(); send_w(8'h07, 8'h5A); tick_n(30);
    check("full_wr", n_wr, 1);
    check("full_no_tx", n_tx, 0);
    check("full_busy", bus.busy, 1);
    bus.tx_full = 1'b0;
    tick_n(10);
    check("full_tx_count", n_tx, 1);
    check("full_tx_byte", tx_byte, 8'h4B);
    check("full_idle", bus.busy, 0);

    // Reset in the middle of a frame
    clr(); push(8'h57); push(8'h05); tick_n(9);
    rst = 1'b0;
    tick_n(1);
    check("mid_rst_strobes", {bus.busy, bus.rx_rd_en, bus.tx_wr_en, bus.reg_wr_en, bus.reg_rd_en, bus.err}, 0);
    check("mid_rst_data", {bus.reg_addr, bus.reg_wr_data, bus.tx_wr_data}, 0);
    tick_n(2);
    rst = 1'b1;
    rd_value = 8'h77;
    clr(); send_r(8'h05); tick_n(40);
    check("post_rst_rd", {n_rd[7:0], rd_addr}, 16'h0105);
    check("post_rst_no_wr", n_wr, 0);
    check("post_rst_tx", tx_byte, 8'h77);
    check("post_rst_no_err", n_err, 0);

`ifdef UART_BRIDGE_CSUM_EN
    clr(); push(8'h57); push(8'h05); push(8'hA5); push(8'hF7); tick_n(40);
    check("csum_ok_wr", n_wr, 1);
    check("csum_ok_tx", tx_byte, 8'h4B);
    clr(); push(8'h57); push(8'h05); push(8'hA5); push(8'h00); tick_n(40);
    check("csum_bad_no_wr", n_wr, 0);
    check("csum_bad_err", n_err, 1);
    check("csum_bad_tx", {n_tx[7:0], tx_byte}, 16'h0145);
`endif

    check("no_wr_rd_overlap", n_both, 0);
    check("no_back_to_back_pop", n_consec, 0);
    check("no_pop_when_empty", n_underflow, 0);
    check("no_push_when_full", n_full_push, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
